// File: rtl/stream_buffer_fifo_pkg.sv
// ============================================================================
// Module   : stream_pkg
// Brief    : Shared constants and helpers for the stream buffer FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stream_pkg;

    localparam int MODE_CUT_THROUGH = 0;
    localparam int MODE_STORE_FWD   = 1;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_buffer_fifo_ram.sv
// ============================================================================
// Module   : stream_fifo_ram
// Brief    : Ring storage with one write port and an asynchronous head read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_fifo_ram
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // First-word-fall-through: the head entry is always visible.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/stream_buffer_fifo.sv
// ============================================================================
// Module   : stream_buffer_fifo
// Brief    : AXI-stream ring-buffer FIFO, cut-through or store-and-forward,
//            with packet counters and occupancy level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_buffer_fifo
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = keep_width(DATA_WIDTH),
    parameter int DEPTH      = 16,
    parameter int MODE       = MODE_CUT_THROUGH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    stream_in_DATA,
    input  logic [KEEP_WIDTH-1:0]    stream_in_KEEP,
    input  logic                     stream_in_LAST,
    input  logic                     stream_in_VALID,
    output logic                     stream_in_READY,
    output logic [DATA_WIDTH-1:0]    stream_out_DATA,
    output logic [KEEP_WIDTH-1:0]    stream_out_KEEP,
    output logic                     stream_out_LAST,
    output logic                     stream_out_VALID,
    input  logic                     stream_out_READY,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_WIDTH-1:0]     pkt_count_in,
    output logic [CNT_WIDTH-1:0]     pkt_count_out
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_LW   = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } beat_t;

    beat_t                w_wr_beat;
    beat_t                w_rd_beat;
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_LW-1:0]      r_level;
    logic [c_LW-1:0]      r_pkts_held;
    logic                 r_forced;
    logic                 r_rst_q;
    logic [CNT_WIDTH-1:0] r_pkt_count_in;
    logic [CNT_WIDTH-1:0] r_pkt_count_out;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_push_last;
    logic                 w_pop_last;
    logic                 w_release;

    assign w_wr_beat = '{data: stream_in_DATA, keep: stream_in_KEEP, last: stream_in_LAST};

    stream_fifo_ram #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_beat),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_beat)
    );

    // Ready is held low while full even if a pop happens this cycle.
    assign stream_in_READY = !r_rst_q && (r_level != c_FULL);

    // Store-and-forward holds the head until a whole packet (or a forced
    // oversize packet) is available.
    assign w_release = (MODE == MODE_STORE_FWD) ? ((r_pkts_held != '0) || r_forced) : 1'b1;

    assign stream_out_VALID = (r_level != '0) && w_release;
    assign stream_out_DATA  = w_rd_beat.data;
    assign stream_out_KEEP  = w_rd_beat.keep;
    assign stream_out_LAST  = w_rd_beat.last;

    assign w_push      = stream_in_VALID && stream_in_READY;
    assign w_pop       = stream_out_VALID && stream_out_READY;
    assign w_push_last = w_push && stream_in_LAST;
    assign w_pop_last  = w_pop && w_rd_beat.last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_q         <= 1'b1;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
            r_pkts_held     <= '0;
            r_forced        <= 1'b0;
            r_pkt_count_in  <= '0;
            r_pkt_count_out <= '0;
        end else begin
            r_rst_q <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level     <= r_level + c_LW'(w_push) - c_LW'(w_pop);
            r_pkts_held <= r_pkts_held + c_LW'(w_push_last) - c_LW'(w_pop_last);
            // A full FIFO with no packet end inside would deadlock; stream it.
            if (w_pop_last) begin
                r_forced <= 1'b0;
            end else if ((MODE == MODE_STORE_FWD) && (r_level == c_FULL) && (r_pkts_held == '0)) begin
                r_forced <= 1'b1;
            end
            if (w_push_last) begin
                r_pkt_count_in <= r_pkt_count_in + CNT_WIDTH'(1);
            end
            if (w_pop_last) begin
                r_pkt_count_out <= r_pkt_count_out + CNT_WIDTH'(1);
            end
        end
    end

    assign level         = r_level;
    assign pkt_count_in  = r_pkt_count_in;
    assign pkt_count_out = r_pkt_count_out;

endmodule

`default_nettype wire

// File: tb/tb_stream_buffer_fifo.sv
// ============================================================================
// Module   : tb_stream_buffer_fifo
// Brief    : Directed bench for stream_buffer_fifo in both modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_buffer_fifo;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] a_in_data,  b_in_data;
    logic [3:0]  a_in_keep,  b_in_keep;
    logic        a_in_last,  b_in_last;
    logic        a_in_valid, b_in_valid;
    logic        a_in_ready, b_in_ready;
    logic [31:0] a_out_data, b_out_data;
    logic [3:0]  a_out_keep, b_out_keep;
    logic        a_out_last, b_out_last;
    logic        a_out_valid, b_out_valid;
    logic        a_out_ready, b_out_ready;
    logic [4:0]  a_level;
    logic [3:0]  b_level;
    logic [31:0] a_pkt_in, a_pkt_out, b_pkt_in, b_pkt_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_buffer_fifo #(
        .DATA_WIDTH (32), .DEPTH (16), .MODE (0), .CNT_WIDTH (32)
    ) u_ct (
        .clk (clk), .rst (rst),
        .stream_in_DATA (a_in_data), .stream_in_KEEP (a_in_keep),
        .stream_in_LAST (a_in_last), .stream_in_VALID (a_in_valid),
        .stream_in_READY (a_in_ready),
        .stream_out_DATA (a_out_data), .stream_out_KEEP (a_out_keep),
        .stream_out_LAST (a_out_last), .stream_out_VALID (a_out_valid),
        .stream_out_READY (a_out_ready),
        .level (a_level), .pkt_count_in (a_pkt_in), .pkt_count_out (a_pkt_out)
    );

    stream_buffer_fifo #(
        .DATA_WIDTH (32), .DEPTH (8), .MODE (1), .CNT_WIDTH (32)
    ) u_sf (
        .clk (clk), .rst (rst),
        .stream_in_DATA (b_in_data), .stream_in_KEEP (b_in_keep),
        .stream_in_LAST (b_in_last), .stream_in_VALID (b_in_valid),
        .stream_in_READY (b_in_ready),
        .stream_out_DATA (b_out_data), .stream_out_KEEP (b_out_keep),
        .stream_out_LAST (b_out_last), .stream_out_VALID (b_out_valid),
        .stream_out_READY (b_out_ready),
        .level (b_level), .pkt_count_in (b_pkt_in), .pkt_count_out (b_pkt_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [36:0] q[$];
        logic [36:0] exp_beat;
        int pushed, npop, popped, exp_pin, exp_pout;
        logic acc;

        rst = 1'b1;
        a_in_data = '0; a_in_keep = '0; a_in_last = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_keep = '0; b_in_last = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_level", a_level, 0);
        chk("rst_pkt_in", a_pkt_in, 0);
        chk("rst_pkt_out", a_pkt_out, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", a_in_ready, 1);
        chk("post_rst_b_in_ready", b_in_ready, 1);

        // ---- cut-through 4-beat packet, 1-cycle latency ----
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'(i); a_in_keep = 4'hF; a_in_last = (i == 4);
            tick();
            chk("ct_valid", a_out_valid, 1);
            chk("ct_data", a_out_data, i);
        end
        a_in_valid = 1'b0; a_in_last = 1'b0;
        tick();
        chk("ct_level_empty", a_level, 0);
        chk("ct_valid_empty", a_out_valid, 0);
        chk("ct_pkt_in", a_pkt_in, 1);
        chk("ct_pkt_out", a_pkt_out, 1);

        // ---- fill to full with output stalled ----
        a_out_ready = 1'b0;
        pushed = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            a_in_valid = 1'b1; a_in_data = 32'h100 + 32'(pushed); a_in_last = (pushed == 19);
            if (a_in_ready) pushed++;
            tick();
        end
        chk("full_accepted", pushed, 16);
        chk("full_level", a_level, 16);
        chk("full_in_ready", a_in_ready, 0);
        chk("full_head", a_out_data, 32'h100);
        a_out_ready = 1'b1;
        tick();
        chk("full_no_bypass_level", a_level, 15);
        npop = 1;
        for (int cyc = 0; cyc < 40 && npop < 20; cyc++) begin
            a_in_valid = (pushed < 20);
            a_in_data  = 32'h100 + 32'(pushed);
            a_in_last  = (pushed == 19);
            if (a_out_valid) begin
                chk("full_drain_data", a_out_data, 32'h100 + 32'(npop));
                npop++;
            end
            if (a_in_valid && a_in_ready) pushed++;
            tick();
        end
        a_in_valid = 1'b0; a_in_last = 1'b0;
        chk("full_drain_count", npop, 20);
        chk("full_drain_level", a_level, 0);
        chk("full_pkt_in", a_pkt_in, 2);
        chk("full_pkt_out", a_pkt_out, 2);

        // ---- store-and-forward with gaps ----
        b_out_ready = 1'b1; b_in_keep = 4'hF;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1; b_in_data = 32'h11 + 32'(i); b_in_last = (i == 2);
            tick();
            b_in_valid = 1'b0; b_in_last = 1'b0;
            if (i < 2) begin
                chk("sf_hold_valid", b_out_valid, 0);
                tick();
                chk("sf_gap_valid", b_out_valid, 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk("sf_valid", b_out_valid, 1);
            chk("sf_data", b_out_data, 32'h11 + 32'(i));
            tick();
        end
        chk("sf_done_valid", b_out_valid, 0);
        chk("sf_pkt_out", b_pkt_out, 1);

        // ---- oversize packet forces cut-through ----
        b_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_in_valid = 1'b1; b_in_data = 32'h20 + 32'(i); b_in_last = 1'b0;
            tick();
        end
        chk("force_level", b_level, 8);
        chk("force_in_ready", b_in_ready, 0);
        chk("force_pre_valid", b_out_valid, 0);
        b_in_data = 32'h28;
        tick();
        chk("force_valid", b_out_valid, 1);
        chk("force_head", b_out_data, 32'h20);
        chk("force_level_hold", b_level, 8);
        b_out_ready = 1'b1;
        pushed = 8; npop = 0;
        for (int cyc = 0; cyc < 40 && npop < 12; cyc++) begin
            b_in_valid = (pushed < 12);
            b_in_data  = 32'h20 + 32'(pushed);
            b_in_last  = (pushed == 11);
            if (b_out_valid) begin
                chk("force_data", b_out_data, 32'h20 + 32'(npop));
                npop++;
            end
            if (b_in_valid && b_in_ready) pushed++;
            tick();
        end
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("force_count", npop, 12);
        chk("force_level_end", b_level, 0);
        chk("force_pkt_in", b_pkt_in, 2);
        chk("force_pkt_out", b_pkt_out, 2);
        // Store-and-forward must resume once the forced packet is gone.
        b_in_valid = 1'b1; b_in_data = 32'h40; b_in_last = 1'b0;
        tick();
        chk("unforce_hold", b_out_valid, 0);
        b_in_data = 32'h41; b_in_last = 1'b1;
        tick();
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("unforce_data0", b_out_data, 32'h40);
        tick();
        chk("unforce_data1", b_out_data, 32'h41);
        tick();
        chk("unforce_level", b_level, 0);

        // ---- random handshakes from level 5 ----
        a_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'h300 + 32'(i); a_in_keep = 4'hF; a_in_last = 1'b0;
            q.push_back({a_in_data, a_in_keep, a_in_last});
            tick();
        end
        a_in_valid = 1'b0;
        chk("rand_setup_level", a_level, 5);
        popped = 0; exp_pin = 2; exp_pout = 2; acc = 1'b0;
        for (int cyc = 0; cyc < 6000 && popped < 1000; cyc++) begin
            if (!a_in_valid || acc) begin
                a_in_valid = $urandom_range(0, 3) != 0;
                a_in_data  = $urandom;
                a_in_keep  = 4'($urandom);
                a_in_last  = $urandom_range(0, 3) == 0;
            end
            a_out_ready = $urandom_range(0, 2) != 0;
            if (a_out_valid && a_out_ready) begin
                exp_beat = q.pop_front();
                chk("rand_beat", {a_out_data, a_out_keep, a_out_last}, exp_beat);
                if (exp_beat[0]) exp_pout++;
                popped++;
            end
            acc = a_in_valid && a_in_ready;
            if (acc) begin
                q.push_back({a_in_data, a_in_keep, a_in_last});
                if (a_in_last) exp_pin++;
            end
            tick();
            chk("rand_level", a_level, q.size());
            chk("rand_level_max", a_level <= 5'd16, 1);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
            if (a_out_valid) begin
                exp_beat = q.pop_front();
                chk("rand_drain_beat", {a_out_data, a_out_keep, a_out_last}, exp_beat);
                if (exp_beat[0]) exp_pout++;
            end
            tick();
        end
        chk("rand_popped", popped, 1000);
        chk("rand_drain_level", a_level, 0);
        chk("rand_pkt_in", a_pkt_in, exp_pin);
        chk("rand_pkt_out", a_pkt_out, exp_pout);

        // ---- reset mid-packet ----
        b_out_ready = 1'b0; b_in_keep = 4'hF;
        for (int i = 0; i < 7; i++) begin
            b_in_valid = 1'b1; b_in_data = 32'h60 + 32'(i); b_in_last = 1'b0;
            tick();
        end
        b_in_valid = 1'b0;
        chk("mid_level", b_level, 7);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", b_level, 0);
        chk("mid_rst_valid", b_out_valid, 0);
        chk("mid_rst_pkt_in", b_pkt_in, 0);
        chk("mid_rst_pkt_out", b_pkt_out, 0);
        chk("mid_rst_in_ready", b_in_ready, 0);
        rst = 1'b0;
        tick();
        chk("mid_post_in_ready", b_in_ready, 1);
        chk("mid_post_valid", b_out_valid, 0);
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 32'h51; b_in_keep = 4'hF; b_in_last = 1'b0;
        tick();
        chk("new_hold", b_out_valid, 0);
        b_in_data = 32'h52; b_in_keep = 4'h0; b_in_last = 1'b1;
        tick();
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("new_valid", b_out_valid, 1);
        chk("new_data0", b_out_data, 32'h51);
        tick();
        chk("new_data1", b_out_data, 32'h52);
        chk("new_keep1", b_out_keep, 4'h0);
        chk("new_last1", b_out_last, 1);
        tick();
        chk("new_level", b_level, 0);
        chk("new_pkt_in", b_pkt_in, 1);
        chk("new_pkt_out", b_pkt_out, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_buffer_fifo.md
Name: stream_buffer_fifo

Overview:
- Parametrised AXI-stream buffer between a stream producer and a stream consumer; generalises the unregistered stream pass-through used in the packet-parser sims.
- Ring-buffer FIFO of DEPTH beats carrying DATA/KEEP/LAST with full VALID/READY handshakes on both sides.
- Two modes: cut-through, and store-and-forward (a packet is released only once its LAST beat is buffered).
- Per-side packet counters and an occupancy level for debug-shell status registers.

Parameters:
- DATA_WIDTH, 64, stream data width in bits; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width (derived; do not override).
- DEPTH, 16, FIFO depth in beats; power of two, >= 2.
- MODE, 0, 0 = cut-through, 1 = store-and-forward.
- CNT_WIDTH, 32, packet-counter width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- stream_in_DATA  in  DATA_WIDTH  input beat data.
- stream_in_KEEP  in  KEEP_WIDTH  input byte enables, passed through unmodified.
- stream_in_LAST  in  1  end-of-packet marker.
- stream_in_VALID  in  1  input beat valid.
- stream_in_READY  out  1  FIFO can accept a beat.
- stream_out_DATA  out  DATA_WIDTH  head-of-FIFO data.
- stream_out_KEEP  out  KEEP_WIDTH  head-of-FIFO byte enables.
- stream_out_LAST  out  1  head-of-FIFO LAST.
- stream_out_VALID  out  1  head beat presentable.
- stream_out_READY  in  1  consumer accepts.
- level  out  $clog2(DEPTH)+1  beats currently stored (0..DEPTH).
- pkt_count_in  out  CNT_WIDTH  accepted beats with LAST=1.
- pkt_count_out  out  CNT_WIDTH  emitted beats with LAST=1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers, level, pkts_held, forced and both counters go to 0.
  - stream_in_READY=0 during reset and 1 from the first cycle after reset.
  - stream_out_VALID=0.
  - DATA/KEEP/LAST outputs don't-care while VALID=0.
  - Reset mid-packet discards all stored beats; no partial packet survives.
- Push: stream_in_VALID & stream_in_READY. Pop: stream_out_VALID & stream_out_READY.
- stream_in_READY = !rst_q & (level != DEPTH).
  - No push when full, even if a pop occurs in the same cycle (registered-ready behaviour; no full-bypass).
- Storage and latency:
  - Head read is first-word-fall-through from the ring.
  - A beat pushed at edge N is visible on stream_out at cycle N+1 (1-cycle latency). There is no same-cycle combinational in-to-out path.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pointer and level arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - level is 0..DEPTH.
- pkts_held (complete packets in FIFO, same width as level):
  - +1 on a push with LAST=1, −1 on a pop with LAST=1, unchanged when both happen in one cycle.
- stream_out_VALID:
  - MODE=0: VALID = (level != 0).
  - MODE=1: VALID = (level != 0) & (pkts_held != 0 | forced).
- forced flag (MODE=1 only):
  - Set when level == DEPTH and pkts_held == 0. This covers a packet longer than DEPTH and prevents deadlock.
  - Cleared on a pop with LAST=1.
  - While set, the FIFO behaves as cut-through until that packet's LAST beat leaves.
- Output holding: once VALID=1, DATA/KEEP/LAST/VALID stay stable until a pop (AXI rule; VALID never drops without a pop).
- Counters:
  - pkt_count_in increments on a push with LAST=1; pkt_count_out increments on a pop with LAST=1.
  - Both wrap modulo 2^CNT_WIDTH.
- KEEP is never interpreted; a LAST beat with KEEP=0 is still a packet end.

Decomposition:
- Package stream_pkg:
  - MODE_CUT_THROUGH=0 and MODE_STORE_FWD=1 constants.
  - A keep_width(DATA_WIDTH) function.
  - A stream beat struct type {data, keep, last} parametrised via typedef in the wrapper.
- Sub-module stream_fifo_ram: simple dual-port ring storage (write port + asynchronous read of head), width DATA_WIDTH+KEEP_WIDTH+1, depth DEPTH.
- Top module: pointers, level, pkts_held, forced, counters and handshakes.

Test Plan:
- MODE=0, DEPTH=16, out READY=1, push 4-beat packet 0x01..0x04 (LAST on 4th) → out beats 0x01..0x04 start 1 cycle after first push; pkt_count_in=pkt_count_out=1; level returns to 0.
- MODE=0, out READY=0, push 20 beats → in READY drops after 16 accepted, level=16; raise out READY → 16 beats emitted in order, remaining 4 accepted afterwards.
- MODE=1, 3-beat packet pushed with gaps, out READY=1 → out VALID stays 0 until the cycle after LAST is pushed, then 3 consecutive beats.
- MODE=1, DEPTH=8, 12-beat packet (no LAST in first 8) → at level=8 forced sets, beats flow cut-through, all 12 delivered, forced clears after LAST pop.
- Simultaneous push and pop at level=5, random READY/VALID for 1000 beats → level never exceeds DEPTH, output order equals input order, KEEP and LAST bit-exact.
- Assert rst mid-packet with level=7 → next cycle level=0, out VALID=0, counters=0; a new packet afterwards passes normally.
